// File: rtl/sll_seq.sv
// ---------------------------------------------------------------------------
// sll_seq -- multi-cycle logical left shifter for the ALU shift path.
//
// One binary-weighted stage is applied per clock (2**(SHAMT_W-1) down to 1),
// zero-filling from the LSB end. A start/done handshake keeps the shifter off
// the single-cycle critical path. The number of cycles is the same for every
// shift amount. The block also reports whether any 1 bit was pushed past the
// MSB, so that multiply-by-power-of-two overflow can be detected.
// WIDTH must equal 2**SHAMT_W.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous, active-high reset (clears every register)
//   start   in   request a shift; accepted only in IDLE or DONE
//   A       in   operand, sampled on the accepting edge
//   select  in   shift amount 0..WIDTH-1, sampled on the accepting edge
//   out     out  registered result; changes only on the completion edge
//   busy    out  high while the stages are being applied
//   done    out  one-cycle pulse; out and lost are valid in that cycle
//   lost    out  a 1 bit was shifted past the MSB; updated together with out
// ---------------------------------------------------------------------------
module sll_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [SHAMT_W-1:0] select,
    output logic [WIDTH-1:0]   out,
    output logic               busy,
    output logic               done,
    output logic               lost
);

    // Stage index width; kept at least one bit wide for degenerate SHAMT_W.
    localparam int K_W    = ($clog2(SHAMT_W) > 0) ? $clog2(SHAMT_W) : 1;
    // Stage distance 2**k needs one bit more than the shift amount.
    localparam int DIST_W = SHAMT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   acc_q,     acc_d;
    logic [SHAMT_W-1:0] sel_q,     sel_d;
    logic [K_W-1:0]     k_q,       k_d;
    logic               lostacc_q, lostacc_d;
    logic [WIDTH-1:0]   out_q,     out_d;
    logic               lost_q,    lost_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;

    logic [DIST_W-1:0]  stage_dist;
    logic [WIDTH-1:0]   acc_next;
    logic               lost_next;
    logic               spill;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        sel_d     = sel_q;
        k_d       = k_q;
        lostacc_d = lostacc_q;
        out_d     = out_q;
        lost_d    = lost_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        // Distance of the current stage and the bits it would push out:
        // the top 2**k bits of the accumulator.
        stage_dist = DIST_W'(1) << k_q;
        spill      = |(acc_q >> (DIST_W'(WIDTH) - stage_dist));

        if (sel_q[k_q]) begin
            acc_next  = acc_q << stage_dist;
            lost_next = lostacc_q | spill;
        end else begin
            acc_next  = acc_q;
            lost_next = lostacc_q;
        end

        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    acc_d     = A;
                    sel_d     = select;
                    k_d       = K_W'(SHAMT_W - 1);
                    lostacc_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end else begin
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                // start is deliberately not looked at here.
                acc_d     = acc_next;
                lostacc_d = lost_next;
                if (k_q == '0) begin
                    out_d   = acc_next;
                    lost_d  = lost_next;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d     = k_q - K_W'(1);
                    busy_d  = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            sel_q     <= '0;
            k_q       <= '0;
            lostacc_q <= 1'b0;
            out_q     <= '0;
            lost_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            sel_q     <= sel_d;
            k_q       <= k_d;
            lostacc_q <= lostacc_d;
            out_q     <= out_d;
            lost_q    <= lost_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;
    assign lost = lost_q;

endmodule

// File: tb/tb_sll_seq.sv
// ---------------------------------------------------------------------------
// tb_sll_seq -- self-checking bench for sll_seq (WIDTH=32, SHAMT_W=5).
// Expected results come from plain arithmetic on a 64-bit product of the
// operand and 2**select; handshake timing is checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_sll_seq;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [4:0]  select;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        lost;

    int          n_cmp;
    int          n_err;
    logic [31:0] last_out;
    logic        last_lost;

    sll_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .select (select),
        .out    (out),
        .busy   (busy),
        .done   (done),
        .lost   (lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full operation starting from IDLE or DONE. When noise is set,
    // start is held high with a different operand throughout SHIFT.
    task automatic run_op(input logic [31:0] a, input logic [4:0] s, input bit noise);
        logic [63:0] wide;
        logic [31:0] exp_out;
        logic        exp_lost;
        wide     = {32'b0, a} << s;
        exp_out  = wide[31:0];
        exp_lost = |wide[63:32];

        A = a; select = s; start = 1'b1;
        tick();                                   // accepting edge
        chk_eq("accept_busy", {31'b0, busy}, 32'd1);
        chk_eq("accept_done", {31'b0, done}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            if (noise) begin
                start = 1'b1; A = 32'hFFFF_FFFF; select = 5'd16;
            end else begin
                start = 1'b0; A = $urandom; select = 5'($urandom);
            end
            tick();
            if (i < 5) begin
                chk_eq("shift_busy", {31'b0, busy}, 32'd1);
                chk_eq("shift_done", {31'b0, done}, 32'd0);
                chk_eq("shift_out_hold", out, last_out);
            end else begin
                chk_eq("done_busy", {31'b0, busy}, 32'd0);
                chk_eq("done_pulse", {31'b0, done}, 32'd1);
                chk_eq("result_out", out, exp_out);
                chk_eq("result_lost", {31'b0, lost}, {31'b0, exp_lost});
            end
        end
        last_out  = exp_out;
        last_lost = exp_lost;
    endtask

    // Return to IDLE and confirm the result is held and done has dropped.
    task automatic idle_check();
        start = 1'b0;
        tick();
        chk_eq("idle_done", {31'b0, done}, 32'd0);
        chk_eq("idle_busy", {31'b0, busy}, 32'd0);
        chk_eq("idle_out_hold", out, last_out);
        chk_eq("idle_lost_hold", {31'b0, lost}, {31'b0, last_lost});
    endtask

    initial begin
        logic [31:0] ra;
        logic [4:0]  rs;
        n_cmp = 0; n_err = 0;
        last_out = 32'h0; last_lost = 1'b0;

        // Reset held two cycles with start asserted.
        reset = 1'b1; start = 1'b1; A = 32'hA5A5_5A5A; select = 5'd3;
        tick(); tick();
        chk_eq("rst_out", out, 32'h0);
        chk_eq("rst_busy", {31'b0, busy}, 32'd0);
        chk_eq("rst_done", {31'b0, done}, 32'd0);
        chk_eq("rst_lost", {31'b0, lost}, 32'd0);
        reset = 1'b0; start = 1'b0;
        tick();
        chk_eq("post_rst_busy", {31'b0, busy}, 32'd0);

        // Directed cases.
        run_op(32'h0000_0001, 5'd31, 1'b0); idle_check();
        run_op(32'hF000_000F, 5'd4,  1'b0); idle_check();
        run_op(32'h0FFF_FFFF, 5'd4,  1'b0); idle_check();
        run_op(32'hDEAD_BEEF, 5'd0,  1'b0); idle_check();
        run_op(32'hFFFF_FFFF, 5'd31, 1'b0); idle_check();

        // start during SHIFT ignored, then accepted in the DONE cycle.
        run_op(32'h0000_0003, 5'd1, 1'b1);
        run_op(32'h0000_0001, 5'd8, 1'b0);
        idle_check();

        // Reset on the third SHIFT edge aborts the operation.
        A = 32'h1234_5678; select = 5'd12; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1; start = 1'b1;
        tick();
        chk_eq("abort_out", out, 32'h0);
        chk_eq("abort_busy", {31'b0, busy}, 32'd0);
        chk_eq("abort_done", {31'b0, done}, 32'd0);
        chk_eq("abort_lost", {31'b0, lost}, 32'd0);
        reset = 1'b0; start = 1'b0;
        last_out = 32'h0; last_lost = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_eq("abort_no_done", {31'b0, done}, 32'd0);
        end
        run_op(32'h1234_5678, 5'd12, 1'b0); idle_check();

        // Randomized operations, mixing idle gaps and back-to-back starts.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rs = 5'd0;
                1:       rs = 5'd31;
                default: rs = 5'($urandom);
            endcase
            run_op(ra, rs, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) != 0) idle_check();
        end
        idle_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
